ret_addr_stack: RTL and testbench
=================================

RET_ADDR_STACK -- requirements
Module: ret_addr_stack

Interface
REQ-001 Parameter ADDR_W, default 16: return-address width in bits.
REQ-002 Parameter DEPTH, default 8: number of entries, power of two, 2 to 64.
REQ-003 Parameter OVF_MODE, default 0: full-stack push policy; 0 = wrap (overwrite oldest), 1 = saturate (reject push).
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port push, input, 1: push {push_addr, push_int} this cycle (branch with save_addr, or interrupt entry).
REQ-007 Port push_addr, input, ADDR_W: return address to store.
REQ-008 Port push_int, input, 1: interrupt-state bit stored with the entry.
REQ-009 Port pop, input, 1: pop top entry this cycle (ret).
REQ-010 Port flush, input, 1: discard all entries.
REQ-011 Port err_clr, input, 1: clear sticky overflow/underflow flags.
REQ-012 Port top_addr, output, ADDR_W: address of current top entry; 0 when empty.
REQ-013 Port top_int, output, 1: interrupt bit of current top entry; 0 when empty.
REQ-014 Port empty, output, 1: count == 0.
REQ-015 Port full, output, 1: count == DEPTH.
REQ-016 Port count, output, $clog2(DEPTH+1): number of valid entries.
REQ-017 Port overflow, output, 1: sticky; set by a push while full without a simultaneous pop.
REQ-018 Port underflow, output, 1: sticky; set by a pop while empty.

Function
REQ-019 Storage: circular buffer of DEPTH entries of width ADDR_W+1, with a top pointer modulo DEPTH and a separate count.
REQ-020 top_addr, top_int, empty, full and count: combinational from registered state; zero added latency, so a pop consumes the value visible in the same cycle.
REQ-021 Push only, not full: pointer increments, entry written, count increments; new top is visible after the edge.
REQ-022 Pop only, not empty: pointer decrements, count decrements; entry contents are not cleared.
REQ-023 Push and pop together, count > 0: top entry is replaced in place; pointer and count are unchanged.
REQ-024 Push and pop together, empty: push is performed (count becomes 1) and underflow is set.
REQ-025 Push while full, no pop, OVF_MODE=0: pointer wraps and the oldest entry is overwritten; count stays DEPTH; overflow is set.
REQ-026 Push while full, no pop, OVF_MODE=1: push is dropped with no state change except setting overflow.
REQ-027 Pop while empty, no push: no state change except setting underflow; top_addr stays 0.
REQ-028 flush has priority over push and pop: count and pointer go to 0 and flags are unaffected.
REQ-029 err_clr clears both flags; a set event in the same cycle wins, so the flag stays 1.
REQ-030 The count arithmetic never exceeds DEPTH and never goes below 0.

Reset
REQ-031 While rst is high, asynchronously: count=0, pointer=0, overflow=0, underflow=0, so top_addr=0, top_int=0, empty=1, full=0.
REQ-032 Entry contents need not be reset; no output may expose them while empty.
REQ-033 Reset asserted mid-operation discards all entries immediately; the first push after deassertion lands at pointer 1.

Verification
REQ-034 DEPTH=8: push 123..130 (push_int=0) -> full=1, count=8; then 8 pops -> top_addr 130,129,...,123 in the pop cycles, then empty=1, top_addr=0.
REQ-035 OVF_MODE=0: push 100..108 -> overflow=1, count=8; 8 pops return 108..101; 9th pop -> underflow=1.
REQ-036 OVF_MODE=1: push 100..108 -> overflow=1; pops return 107..100.
REQ-037 Push 500 with push_int=1, then push 600 and pop together -> count=1, top_addr=600, top_int=0; push and pop on empty -> count=1, underflow=1.
REQ-038 Push 3 entries, then flush and push together -> count=0; err_clr -> flags 0; rst pulse mid-sequence -> outputs match REQ-031 with no clock edge.

Source files
------------

// File: rtl/ret_addr_stack.sv
// Return-address stack: circular buffer with top pointer and count. Top/flags are combinational from state (zero latency).
// No backpressure: a push while full overwrites the oldest entry (OVF_MODE=0) or is dropped (OVF_MODE=1); misuse raises sticky flags.
module ret_addr_stack #(
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 8,
    parameter int OVF_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic                         push_int,
    input  logic                         pop,
    input  logic                         flush,
    input  logic                         err_clr,
    output logic [ADDR_W-1:0]            top_addr,
    output logic                         top_int,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_W:0] mem [DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_inc;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   wr_idx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            wr_en;
    logic            ovf_set;
    logic            unf_set;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    assign top_addr = empty ? '0 : mem[ptr][ADDR_W-1:0];
    assign top_int  = empty ? 1'b0 : mem[ptr][ADDR_W];
    assign ptr_inc  = ptr + 1'b1;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = ptr;
        ptr_nxt = ptr;
        cnt_nxt = cnt;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (flush) begin
            ptr_nxt = '0;
            cnt_nxt = '0;
        end else if (push && pop) begin
            wr_en = 1'b1;
            if (empty) begin
                // Nothing to return, but the new entry is still kept.
                wr_idx  = ptr_inc;
                ptr_nxt = ptr_inc;
                cnt_nxt = CW'(1);
                unf_set = 1'b1;
            end
        end else if (push) begin
            if (!full || OVF_MODE == 0) begin
                wr_en   = 1'b1;
                wr_idx  = ptr_inc;
                ptr_nxt = ptr_inc;
            end
            if (full) ovf_set = 1'b1;
            else      cnt_nxt = cnt + 1'b1;
        end else if (pop) begin
            if (empty) begin
                unf_set = 1'b1;
            end else begin
                ptr_nxt = ptr - 1'b1;
                cnt_nxt = cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            // A set event in the same cycle as err_clr keeps the flag high.
            overflow  <= ovf_set | (overflow  & ~err_clr);
            underflow <= unf_set | (underflow & ~err_clr);
        end
    end

    // Entry contents are never exposed while empty, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= {push_int, push_addr};
    end
endmodule

// File: tb/tb_ret_addr_stack.sv
// Drives a wrap-mode and a saturate-mode stack with identical stimulus and checks both against a list model.
module tb_ret_addr_stack;
    localparam int AW = 16;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0, push_int = 1'b0, pop = 1'b0, flush = 1'b0, err_clr = 1'b0;
    logic [AW-1:0] push_addr = '0;

    logic [AW-1:0] top_addr_w [2];
    logic          top_int_w  [2];
    logic          empty_w    [2];
    logic          full_w     [2];
    logic [3:0]    count_w    [2];
    logic          ovf_w      [2];
    logic          unf_w      [2];

    int n_chk  = 0;
    int n_fail = 0;

    ret_addr_stack #(.ADDR_W(AW), .DEPTH(D), .OVF_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .push(push), .push_addr(push_addr), .push_int(push_int),
        .pop(pop), .flush(flush), .err_clr(err_clr),
        .top_addr(top_addr_w[0]), .top_int(top_int_w[0]), .empty(empty_w[0]), .full(full_w[0]),
        .count(count_w[0]), .overflow(ovf_w[0]), .underflow(unf_w[0]));

    ret_addr_stack #(.ADDR_W(AW), .DEPTH(D), .OVF_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .push(push), .push_addr(push_addr), .push_int(push_int),
        .pop(pop), .flush(flush), .err_clr(err_clr),
        .top_addr(top_addr_w[1]), .top_int(top_int_w[1]), .empty(empty_w[1]), .full(full_w[1]),
        .count(count_w[1]), .overflow(ovf_w[1]), .underflow(unf_w[1]));

    always #5 clk = ~clk;

    // Model: per mode, a list of entries with index 0 the oldest and mc-1 the top.
    logic [AW:0] st [2][D];
    int          mc [2];
    bit          mo [2];
    bit          mu [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                mc[m] = 0; mo[m] = 0; mu[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                logic [AW:0] ent;
                bit so, su;
                ent = {push_int, push_addr};
                so = 0; su = 0;
                if (flush) begin
                    mc[m] = 0;
                end else if (push && pop) begin
                    if (mc[m] > 0) st[m][mc[m]-1] = ent;
                    else begin st[m][0] = ent; mc[m] = 1; su = 1; end
                end else if (push) begin
                    if (mc[m] < D) begin
                        st[m][mc[m]] = ent; mc[m]++;
                    end else begin
                        so = 1;
                        if (m == 0) begin
                            for (int k = 0; k < D-1; k++) st[m][k] = st[m][k+1];
                            st[m][D-1] = ent;
                        end
                    end
                end else if (pop) begin
                    if (mc[m] > 0) mc[m]--;
                    else su = 1;
                end
                mo[m] = so | (mo[m] & ~err_clr);
                mu[m] = su | (mu[m] & ~err_clr);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            int ea, ei;
            ea = (mc[m] > 0) ? int'(st[m][mc[m]-1][AW-1:0]) : 0;
            ei = (mc[m] > 0) ? int'(st[m][mc[m]-1][AW]) : 0;
            chk($sformatf("m%0d top_addr", m), int'(top_addr_w[m]), ea);
            chk($sformatf("m%0d top_int", m), int'(top_int_w[m]), ei);
            chk($sformatf("m%0d count", m), int'(count_w[m]), mc[m]);
            chk($sformatf("m%0d empty", m), int'(empty_w[m]), int'(mc[m] == 0));
            chk($sformatf("m%0d full", m), int'(full_w[m]), int'(mc[m] == D));
            chk($sformatf("m%0d overflow", m), int'(ovf_w[m]), int'(mo[m]));
            chk($sformatf("m%0d underflow", m), int'(unf_w[m]), int'(mu[m]));
        end
    end

    task automatic drive(input bit p, input int a, input bit i, input bit po,
                         input bit f = 0, input bit c = 0);
        @(posedge clk);
        #2;
        push = p; push_addr = AW'(a); push_int = i; pop = po; flush = f; err_clr = c;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst empty", int'(empty_w[0]), 1);
        chk("rst count", int'(count_w[0]), 0);
        chk("rst top_addr", int'(top_addr_w[0]), 0);
        chk("rst full", int'(full_w[0]), 0);
        rst = 1'b0;

        // Fill to full, then pop everything back in LIFO order.
        for (int k = 0; k < 8; k++) drive(1, 123 + k, 0, 0);
        idle();
        chk("fill full", int'(full_w[0]), 1);
        chk("fill count", int'(count_w[0]), 8);
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 1);
            chk($sformatf("lifo pop %0d", k), int'(top_addr_w[0]), 130 - k);
        end
        idle();
        chk("drained empty", int'(empty_w[0]), 1);
        chk("drained top", int'(top_addr_w[0]), 0);

        // One push too many: wrap mode loses 100, saturate mode loses 108.
        for (int k = 0; k < 9; k++) drive(1, 100 + k, 0, 0);
        idle();
        chk("wrap ovf", int'(ovf_w[0]), 1);
        chk("wrap count", int'(count_w[0]), 8);
        chk("sat ovf", int'(ovf_w[1]), 1);
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 1);
            chk($sformatf("wrap pop %0d", k), int'(top_addr_w[0]), 108 - k);
            chk($sformatf("sat pop %0d", k), int'(top_addr_w[1]), 107 - k);
        end
        drive(0, 0, 0, 1);
        idle();
        chk("pop empty unf", int'(unf_w[0]), 1);
        chk("pop empty top", int'(top_addr_w[0]), 0);

        // Push and pop together replaces the top entry in place.
        drive(1, 500, 1, 0);
        drive(1, 600, 0, 1);
        idle();
        chk("replace count", int'(count_w[0]), 1);
        chk("replace top", int'(top_addr_w[0]), 600);
        chk("replace int", int'(top_int_w[0]), 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1);
        idle();
        chk("clr unf", int'(unf_w[0]), 0);
        drive(1, 700, 0, 1);
        idle();
        chk("pp empty count", int'(count_w[0]), 1);
        chk("pp empty unf", int'(unf_w[0]), 1);
        chk("pp empty top", int'(top_addr_w[0]), 700);

        // Flush beats push, leaves flags alone; err_clr then clears them.
        for (int k = 1; k <= 3; k++) drive(1, k, 0, 0);
        drive(1, 9, 0, 0, 1, 0);
        idle();
        chk("flush count", int'(count_w[0]), 0);
        chk("flush keeps unf", int'(unf_w[0]), 1);
        drive(0, 0, 0, 0, 0, 1);
        idle();
        chk("err_clr ovf", int'(ovf_w[0]), 0);
        chk("err_clr unf", int'(unf_w[0]), 0);

        // Reset pulse between clock edges clears everything at once.
        drive(0, 0, 0, 1);
        drive(1, 11, 1, 0);
        drive(1, 12, 1, 0);
        idle();
        chk("pre-rst count", int'(count_w[0]), 2);
        chk("pre-rst unf", int'(unf_w[0]), 1);
        #1 rst = 1'b1;
        #1;
        chk("async rst count", int'(count_w[0]), 0);
        chk("async rst top", int'(top_addr_w[0]), 0);
        chk("async rst int", int'(top_int_w[0]), 0);
        chk("async rst empty", int'(empty_w[0]), 1);
        chk("async rst full", int'(full_w[0]), 0);
        chk("async rst unf", int'(unf_w[0]), 0);
        rst = 1'b0;
        drive(1, 13, 0, 0);
        idle();
        chk("post-rst top", int'(top_addr_w[0]), 13);
        chk("post-rst count", int'(count_w[0]), 1);

        // Random phase: alternating push-heavy and pop-heavy stretches.
        for (int n = 0; n < 3000; n++) begin
            int r, pw;
            bit p, po, f, c, rs;
            pw = ((n / 200) % 2 == 0) ? 65 : 30;
            r  = $urandom_range(0, 99);
            p  = (r < pw);
            po = ($urandom_range(0, 99) < 45);
            f  = ($urandom_range(0, 99) < 2);
            c  = ($urandom_range(0, 99) < 5);
            rs = ($urandom_range(0, 299) == 0);
            drive(p, int'($urandom_range(0, 65535)), bit'($urandom_range(0, 1)), po, f, c);
            rst = rs;
        end
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
